// File: rtl/satd_hadamard_engine_pkg.sv
// Shared types and width helpers for the SATD/SAD engine.
//   state_t  : engine FSM states
//   log2n    : log2 of the block size (N = 4 -> 2, N = 8 -> 3)
//   d_w      : signed pixel-difference width
//   h_w      : signed coefficient width after both Hadamard passes
//   sum_w    : unsigned block-cost width
package satd_pkg;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      DRAIN = 2'd1,
      OUT   = 2'd2
   } state_t;

   function automatic int log2n(input int n);
      return $clog2(n);
   endfunction

   function automatic int d_w(input int pix_w);
      return pix_w + 1;
   endfunction

   function automatic int h_w(input int n, input int pix_w);
      return d_w(pix_w) + 2 * log2n(n);
   endfunction

   function automatic int sum_w(input int n, input int pix_w);
      return h_w(n, pix_w) + 2 * log2n(n);
   endfunction

endpackage

// File: rtl/satd_hadamard_engine_hadamard_1d.sv
// Combinational N-point Hadamard transform, Sylvester (natural) order:
//   y[k] = sum_j (-1)^popcount(j & k) * x[j]
// Ports:
//   x_i : N signed inputs of IN_W bits, element i at x_i[i*IN_W +: IN_W]
//   y_o : N signed outputs of IN_W+log2(N) bits, same packing
// Each butterfly stage can grow the magnitude by one bit, so every stage
// runs at the full output width and nothing is ever truncated.
module hadamard_1d #(
   parameter int N    = 8,
   parameter int IN_W = 9
) (
   input  logic [N*IN_W-1:0]           x_i,
   output logic [N*(IN_W+$clog2(N))-1:0] y_o
);

   localparam int LOG2N = $clog2(N);
   localparam int OUT_W = IN_W + LOG2N;

   logic signed [OUT_W-1:0] st [LOG2N+1][N];
   logic signed [IN_W-1:0]  x_elem;
   int                      lo;
   int                      hi;

   always_comb begin
      st     = '{default: '0};
      x_elem = '0;
      lo     = 0;
      hi     = 0;
      y_o    = '0;
      for (int i = 0; i < N; i++) begin
         x_elem   = x_i[i*IN_W +: IN_W];
         st[0][i] = OUT_W'(x_elem);
      end
      // Stage s pairs element lo with lo + 2^s; (lo, hi) is enumerated directly
      // from the pair index so every index stays in range.
      for (int s = 0; s < LOG2N; s++) begin
         for (int j = 0; j < N / 2; j++) begin
            lo = ((j >> s) << (s + 1)) | (j & ((1 << s) - 1));
            hi = lo | (1 << s);
            st[s+1][lo] = st[s][lo] + st[s][hi];
            st[s+1][hi] = st[s][lo] - st[s][hi];
         end
      end
      for (int i = 0; i < N; i++) begin
         y_o[i*OUT_W +: OUT_W] = st[LOG2N][i];
      end
   end

endmodule

// File: rtl/satd_hadamard_engine.sv
// Row-streamed SATD/SAD cost engine for one NxN block.
// Ports:
//   CLK, RST           : clock, synchronous active-low reset
//   ORG, CUR           : one row of original / candidate pixels, pixel i at [i*PIX_W +: PIX_W]
//   mode               : 0 = SATD, 1 = SAD, taken from row 0 of each block
//   in_valid, in_ready : row handshake
//   satd               : raw block cost (no /2 normalisation)
//   out_valid, out_ready : result handshake
//
// state | meaning
// FILL  | accept rows, row pass (or raw diff in SAD) written to transpose buffer
// DRAIN | one buffer column per cycle: column pass, abs, sum, accumulate
// OUT   | hold satd/out_valid until out_ready
module satd_hadamard_engine
   import satd_pkg::*;
#(
   parameter int N     = 8,
   parameter int PIX_W = 8
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic [N*PIX_W-1:0]         ORG,
   input  logic [N*PIX_W-1:0]         CUR,
   input  logic                       mode,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [sum_w(N, PIX_W)-1:0] satd,
   output logic                       out_valid,
   input  logic                       out_ready
);

   localparam int LOG2N = log2n(N);
   localparam int D_W   = d_w(PIX_W);
   localparam int B_W   = D_W + LOG2N;
   localparam int H_W   = h_w(N, PIX_W);
   localparam int SUM_W = sum_w(N, PIX_W);
   localparam int C_W   = H_W + LOG2N;

   state_t                  state_q,     state_d;
   logic [LOG2N-1:0]        row_cnt_q,   row_cnt_d;
   logic [LOG2N-1:0]        col_cnt_q,   col_cnt_d;
   logic                    mode_q,      mode_d;
   logic [C_W-1:0]          col_sum_q,   col_sum_d;
   logic                    col_vld_q,   col_vld_d;
   logic                    col_last_q,  col_last_d;
   logic [SUM_W-1:0]        acc_q,       acc_d;
   logic [SUM_W-1:0]        satd_q,      satd_d;
   logic                    out_valid_q, out_valid_d;
   logic signed [B_W-1:0]   buf_q [N][N];
   logic signed [B_W-1:0]   buf_d [N][N];

   logic [N*D_W-1:0]        diff_row;
   logic [N*B_W-1:0]        row_h;
   logic [N*B_W-1:0]        col_vec;
   logic [N*H_W-1:0]        col_h;
   logic signed [B_W-1:0]   wr_row [N];
   logic signed [D_W-1:0]   d_elem;
   logic signed [H_W-1:0]   cv;
   logic [H_W-1:0]          ca;
   logic [C_W-1:0]          col_sum_c;
   logic                    row_mode;
   logic                    in_fire;

   assign in_ready  = RST && (state_q == FILL);
   assign in_fire   = in_valid && in_ready;
   assign satd      = satd_q;
   assign out_valid = out_valid_q;
   // Row 0 of the block has not latched its mode yet, so use the port directly.
   assign row_mode  = (row_cnt_q == '0) ? mode : mode_q;

   always_comb begin
      diff_row = '0;
      for (int i = 0; i < N; i++) begin
         diff_row[i*D_W +: D_W] = {1'b0, ORG[i*PIX_W +: PIX_W]} - {1'b0, CUR[i*PIX_W +: PIX_W]};
      end
   end

   hadamard_1d #(.N(N), .IN_W(D_W)) u_row_pass (
      .x_i (diff_row),
      .y_o (row_h)
   );

   always_comb begin
      wr_row = '{default: '0};
      d_elem = '0;
      for (int i = 0; i < N; i++) begin
         d_elem    = diff_row[i*D_W +: D_W];
         wr_row[i] = row_mode ? B_W'(d_elem) : row_h[i*B_W +: B_W];
      end
   end

   always_comb begin
      col_vec = '0;
      for (int r = 0; r < N; r++) begin
         col_vec[r*B_W +: B_W] = buf_q[r][col_cnt_q];
      end
   end

   hadamard_1d #(.N(N), .IN_W(B_W)) u_col_pass (
      .x_i (col_vec),
      .y_o (col_h)
   );

   // The coefficient range never reaches the most-negative H_W value, so the
   // two's-complement negate below is always exact.
   always_comb begin
      col_sum_c = '0;
      cv        = '0;
      ca        = '0;
      for (int r = 0; r < N; r++) begin
         cv        = mode_q ? H_W'(buf_q[r][col_cnt_q]) : col_h[r*H_W +: H_W];
         ca        = cv[H_W-1] ? -cv : cv;
         col_sum_c = col_sum_c + C_W'(ca);
      end
   end

   always_comb begin
      state_d     = state_q;
      row_cnt_d   = row_cnt_q;
      col_cnt_d   = col_cnt_q;
      mode_d      = mode_q;
      col_sum_d   = col_sum_q;
      col_vld_d   = 1'b0;
      col_last_d  = 1'b0;
      acc_d       = acc_q;
      satd_d      = satd_q;
      out_valid_d = out_valid_q;
      buf_d       = buf_q;
      case (state_q)
         FILL: begin
            if (in_fire) begin
               for (int i = 0; i < N; i++) begin
                  buf_d[row_cnt_q][i] = wr_row[i];
               end
               if (row_cnt_q == '0) begin
                  mode_d = mode;
                  acc_d  = '0;
               end
               row_cnt_d = row_cnt_q + LOG2N'(1);
               if (row_cnt_q == LOG2N'(N - 1)) begin
                  col_cnt_d = '0;
                  state_d   = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (col_vld_q) begin
               acc_d = acc_q + SUM_W'(col_sum_q);
            end
            // col_last_q marks the cycle where the final column sum is being
            // added; the total goes straight to the output register.
            if (col_last_q) begin
               satd_d      = acc_q + SUM_W'(col_sum_q);
               out_valid_d = 1'b1;
               state_d     = OUT;
            end else begin
               col_sum_d  = col_sum_c;
               col_vld_d  = 1'b1;
               col_last_d = (col_cnt_q == LOG2N'(N - 1));
               col_cnt_d  = col_cnt_q + LOG2N'(1);
            end
         end
         OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = FILL;
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q     <= FILL;
         row_cnt_q   <= '0;
         col_cnt_q   <= '0;
         mode_q      <= 1'b0;
         col_sum_q   <= '0;
         col_vld_q   <= 1'b0;
         col_last_q  <= 1'b0;
         acc_q       <= '0;
         satd_q      <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_cnt_q   <= row_cnt_d;
         col_cnt_q   <= col_cnt_d;
         mode_q      <= mode_d;
         col_sum_q   <= col_sum_d;
         col_vld_q   <= col_vld_d;
         col_last_q  <= col_last_d;
         acc_q       <= acc_d;
         satd_q      <= satd_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Buffer contents are always rewritten before they are read, so no reset.
   always_ff @(posedge CLK) begin
      buf_q <= buf_d;
   end

endmodule

// File: tb/tb_satd_hadamard_engine.sv
module tb_satd_hadamard_engine;

   localparam int PAT_FLAT  = 0;
   localparam int PAT_DELTA = 1;
   localparam int PAT_MAX   = 2;
   localparam int PAT_MIN   = 3;
   localparam int PAT_RAND  = 4;

   typedef struct {
      int     n;
      int     md;
      int     pat;
      int     gap;
      longint exp_satd;   // -1: take expectation from the reference model
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] org_bus, cur_bus;
   logic        mode;
   logic        iv4, iv8, rdy4, rdy8, ov4, ov8, ordy4, ordy8;
   logic [16:0] satd4;
   logic [20:0] satd8;

   always #5 clk = ~clk;

   satd_hadamard_engine #(.N(4), .PIX_W(8)) u_dut4 (
      .CLK(clk), .RST(rst_n), .ORG(org_bus[31:0]), .CUR(cur_bus[31:0]), .mode(mode),
      .in_valid(iv4), .in_ready(rdy4), .satd(satd4), .out_valid(ov4), .out_ready(ordy4)
   );

   satd_hadamard_engine #(.N(8), .PIX_W(8)) u_dut8 (
      .CLK(clk), .RST(rst_n), .ORG(org_bus), .CUR(cur_bus), .mode(mode),
      .in_valid(iv8), .in_ready(rdy8), .satd(satd8), .out_valid(ov8), .out_ready(ordy8)
   );

   int n_vec = 0;
   int n_bad = 0;
   int po [8][8];
   int pc [8][8];

   task automatic check(input string name, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int hsign(input int a, input int b);
      return ($countones(a & b) % 2 == 1) ? -1 : 1;
   endfunction

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   // Cost straight from the definition: SAD = sum |D|, SATD = sum |H * D * H|.
   function automatic longint ref_cost(input int n, input int md);
      int     d [8][8];
      int     t [8][8];
      int     u;
      longint s = 0;
      for (int i = 0; i < n; i++)
         for (int j = 0; j < n; j++)
            d[i][j] = po[i][j] - pc[i][j];
      if (md == 1) begin
         for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++)
               s += iabs(d[i][j]);
      end else begin
         for (int i = 0; i < n; i++)
            for (int v = 0; v < n; v++) begin
               t[i][v] = 0;
               for (int j = 0; j < n; j++) t[i][v] += d[i][j] * hsign(j, v);
            end
         for (int k = 0; k < n; k++)
            for (int v = 0; v < n; v++) begin
               u = 0;
               for (int i = 0; i < n; i++) u += hsign(k, i) * t[i][v];
               s += iabs(u);
            end
      end
      return s;
   endfunction

   task automatic fill(input int pat);
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++) begin
            case (pat)
               PAT_FLAT:  begin po[i][j] = 10;  pc[i][j] = 10;  end
               PAT_DELTA: begin po[i][j] = (i == 0 && j == 0) ? 13 : 10; pc[i][j] = 10; end
               PAT_MAX:   begin po[i][j] = 255; pc[i][j] = 0;   end
               PAT_MIN:   begin po[i][j] = 0;   pc[i][j] = 255; end
               default:   begin po[i][j] = int'($urandom_range(0, 255));
                                pc[i][j] = int'($urandom_range(0, 255)); end
            endcase
         end
   endtask

   function automatic logic get_rdy(input int n); return (n == 4) ? rdy4 : rdy8; endfunction
   function automatic logic get_ov(input int n);  return (n == 4) ? ov4 : ov8;   endfunction
   function automatic longint get_satd(input int n);
      return (n == 4) ? longint'(satd4) : longint'(satd8);
   endfunction

   task automatic set_iv(input int n, input logic v);
      if (n == 4) iv4 = v; else iv8 = v;
   endtask

   task automatic set_ordy(input int n, input logic v);
      if (n == 4) ordy4 = v; else ordy8 = v;
   endtask

   task automatic send_row(input int n, input int r, input int md);
      bit ok = 0;
      for (int i = 0; i < 8; i++) begin
         org_bus[i*8 +: 8] = 8'(po[r][i]);
         cur_bus[i*8 +: 8] = 8'(pc[r][i]);
      end
      mode = md[0];
      set_iv(n, 1'b1);
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (get_rdy(n)) begin ok = 1; break; end
      end
      if (!ok) check("row_accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      set_iv(n, 1'b0);
      org_bus = $urandom();
      mode    = ~mode;
   endtask

   // Sends one block; returns the cost and the number of edges from the
   // acceptance of the last row to out_valid (-1 if it never came).
   task automatic run_block(input int n, input int md, input int gap, input int flip,
                            output longint res, output int lat);
      int rm;
      for (int r = 0; r < n; r++) begin
         rm = (flip != 0 && r > 0) ? 1 - md : md;
         if (gap != 0 && r > 0) begin
            @(posedge clk);
            #1;
         end
         send_row(n, r, rm);
      end
      lat = -1;
      for (int k = 1; k <= 4 * n + 10; k++) begin
         @(posedge clk);
         #1;
         if (k <= n) check("in_ready_drain", longint'(get_rdy(n)), 0);
         if (get_ov(n)) begin lat = k; break; end
      end
      res = get_satd(n);
   endtask

   task automatic consume(input int n);
      set_ordy(n, 1'b1);
      @(posedge clk);
      #1;
      set_ordy(n, 1'b0);
      check("out_valid_after_ack", longint'(get_ov(n)), 0);
      check("in_ready_after_ack", longint'(get_rdy(n)), 1);
   endtask

   vec_t   vecs [$];
   longint res;
   longint exp;
   int     lat;

   initial begin
      rst_n = 1'b0; org_bus = '0; cur_bus = '0; mode = 1'b0;
      iv4 = 1'b0; iv8 = 1'b0; ordy4 = 1'b0; ordy8 = 1'b0;

      vecs.push_back('{n: 4, md: 0, pat: PAT_FLAT,  gap: 0, exp_satd: 0});
      vecs.push_back('{n: 4, md: 0, pat: PAT_DELTA, gap: 0, exp_satd: 48});
      vecs.push_back('{n: 4, md: 1, pat: PAT_DELTA, gap: 0, exp_satd: 3});
      vecs.push_back('{n: 8, md: 0, pat: PAT_MAX,   gap: 0, exp_satd: 16320});
      vecs.push_back('{n: 8, md: 0, pat: PAT_MIN,   gap: 0, exp_satd: 16320});
      vecs.push_back('{n: 8, md: 1, pat: PAT_MAX,   gap: 0, exp_satd: 16320});
      vecs.push_back('{n: 4, md: 1, pat: PAT_MIN,   gap: 1, exp_satd: 4080});
      for (int i = 0; i < 12; i++)
         vecs.push_back('{n: (i % 2 == 0) ? 4 : 8, md: int'($urandom_range(0, 1)),
                          pat: PAT_RAND, gap: int'($urandom_range(0, 1)), exp_satd: -1});

      repeat (3) @(posedge clk);
      #1;
      check("reset_in_ready4", longint'(rdy4), 0);
      check("reset_in_ready8", longint'(rdy8), 0);
      check("reset_out_valid4", longint'(ov4), 0);
      check("reset_satd8", longint'(satd8), 0);
      rst_n = 1'b1;
      #1;
      check("post_reset_in_ready4", longint'(rdy4), 1);
      check("post_reset_in_ready8", longint'(rdy8), 1);

      foreach (vecs[v]) begin
         fill(vecs[v].pat);
         exp = (vecs[v].exp_satd < 0) ? ref_cost(vecs[v].n, vecs[v].md) : vecs[v].exp_satd;
         run_block(vecs[v].n, vecs[v].md, vecs[v].gap, 0, res, lat);
         check($sformatf("vec%0d_latency", v), lat, vecs[v].n + 1);
         check($sformatf("vec%0d_satd", v), res, exp);
         consume(vecs[v].n);
      end

      // Result held while the consumer stalls.
      fill(PAT_DELTA);
      run_block(4, 0, 0, 0, res, lat);
      check("stall_latency", lat, 5);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         check("stall_satd", longint'(satd4), 48);
         check("stall_out_valid", longint'(ov4), 1);
         check("stall_in_ready", longint'(rdy4), 0);
      end
      consume(4);

      // Reset after two rows discards the partial block.
      fill(PAT_MAX);
      send_row(4, 0, 0);
      send_row(4, 1, 0);
      rst_n = 1'b0;
      #1;
      check("midreset_in_ready", longint'(rdy4), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      check("midreset_out_valid", longint'(ov4), 0);
      check("midreset_satd", longint'(satd4), 0);
      check("midreset_in_ready_after", longint'(rdy4), 1);
      fill(PAT_DELTA);
      run_block(4, 0, 0, 0, res, lat);
      check("after_reset_satd", res, 48);
      check("after_reset_latency", lat, 5);
      consume(4);

      // Gapped rows with mode flipping on rows 1..N-1: row-0 mode wins.
      for (int md = 0; md < 2; md++) begin
         for (int nn = 4; nn <= 8; nn += 4) begin
            fill(PAT_RAND);
            exp = ref_cost(nn, md);
            run_block(nn, md, 1, 1, res, lat);
            check($sformatf("modeflip_n%0d_m%0d_satd", nn, md), res, exp);
            check($sformatf("modeflip_n%0d_m%0d_latency", nn, md), lat, nn + 1);
            consume(nn);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
